// File: rtl/rou_pkg.sv
// Shared roubus definitions: flit kinds, ack codes, field offsets, flit layout
// and the ring-stop state encoding.
package rou_pkg;

    localparam int unsigned DWID_DEF = 128;
    localparam int unsigned AWID_DEF = 32;
    localparam int unsigned CWID_DEF = 8;

    localparam logic [1:0] K_IDLE = 2'b00;
    localparam logic [1:0] K_WR   = 2'b01;
    localparam logic [1:0] K_RD   = 2'b10;
    localparam logic [1:0] K_RSP  = 2'b11;

    localparam logic [2:0] ACK_NONE  = 3'b000;
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_RETRY = 3'b010;
    localparam logic [2:0] ACK_ERR   = 3'b100;

    // Flit is {kind, cmd, addr, data} MSB first, so data sits at bit 0.
    function automatic int unsigned addr_lsb(int unsigned dwid);
        return dwid;
    endfunction

    function automatic int unsigned cmd_lsb(int unsigned dwid, int unsigned awid);
        return dwid + awid;
    endfunction

    function automatic int unsigned kind_lsb(int unsigned dwid, int unsigned awid,
                                             int unsigned cwid);
        return dwid + awid + cwid;
    endfunction

    typedef struct packed {
        logic [1:0]          kind;
        logic [CWID_DEF-1:0] cmd;
        logic [AWID_DEF-1:0] addr;
        logic [DWID_DEF-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCAL = 2'd1,
        ST_RESP  = 2'd2,
        ST_FWD   = 2'd3
    } state_t;

endpackage

// File: rtl/rou_hit.sv
// Local address window decode: hit when BASE <= addr < BASE+SIZE, plus the
// window-relative offset.
module rou_hit #(
    parameter int unsigned     AWID = 32,
    parameter logic [AWID-1:0] BASE = 32'h1000_0000,
    parameter logic [AWID-1:0] SIZE = 32'h0000_1000
) (
    input  logic [AWID-1:0] addr_i,
    output logic            hit_o,
    output logic [AWID-1:0] off_o
);

    // One extra bit keeps a window ending at the top of the space from wrapping.
    logic [AWID:0] end_w;

    assign end_w = {1'b0, BASE} + {1'b0, SIZE};
    assign hit_o = (addr_i >= BASE) && ({1'b0, addr_i} < end_w);
    assign off_o = addr_i - BASE;

endmodule

// File: rtl/rou_target.sv
// Roubus ring stop: serves requests that hit the local window through a simple
// slave port and returns a response flit; all other traffic is forwarded.
module rou_target
    import rou_pkg::*;
#(
    parameter int unsigned     DWID    = 128,
    parameter int unsigned     AWID    = 32,
    parameter int unsigned     CWID    = 8,
    parameter int unsigned     WID     = 2 + DWID + AWID + CWID,
    parameter logic [AWID-1:0] BASE    = 32'h1000_0000,
    parameter logic [AWID-1:0] SIZE    = 32'h0000_1000,
    parameter int unsigned     LOC_TMO = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WID-1:0]  rou_in,
    output logic [2:0]      ack_in,
    output logic [WID-1:0]  rou_out,
    input  logic [2:0]      ack_out,
    output logic            loc_req,
    output logic            loc_we,
    output logic [AWID-1:0] loc_addr,
    output logic [DWID-1:0] loc_wdata,
    input  logic [DWID-1:0] loc_rdata,
    input  logic            loc_ack,
    output logic [7:0]      err_cnt
);

    localparam int unsigned KL = kind_lsb(DWID, AWID, CWID);
    localparam int unsigned AL = addr_lsb(DWID);
    localparam int unsigned TW = $clog2(LOC_TMO + 1);

    state_t          state_q;
    logic [WID-1:0]  flit_q;
    logic [AWID-1:0] off_q;
    logic [TW-1:0]   tmo_q;
    logic [2:0]      ack_in_q;
    logic [WID-1:0]  rou_out_q;
    logic [7:0]      err_q;

    logic [1:0]      in_kind;
    logic            in_new;
    logic            in_hit;
    logic [AWID-1:0] in_off;
    logic            out_vld;
    logic [7:0]      err_inc;

    rou_hit #(
        .AWID (AWID),
        .BASE (BASE),
        .SIZE (SIZE)
    ) u_hit (
        .addr_i (rou_in[AL +: AWID]),
        .hit_o  (in_hit),
        .off_o  (in_off)
    );

    assign in_kind = rou_in[KL +: 2];
    // A flit still present while we show ACK_OK is the one we already took.
    assign in_new  = (in_kind != K_IDLE) && (ack_in_q != ACK_OK);
    assign out_vld = (rou_out_q[KL +: 2] != K_IDLE);
    assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            flit_q    <= '0;
            off_q     <= '0;
            tmo_q     <= '0;
            ack_in_q  <= ACK_NONE;
            rou_out_q <= '0;
            err_q     <= '0;
        end else begin
            ack_in_q <= ACK_NONE;
            if (in_new)
                ack_in_q <= (state_q == ST_IDLE) ? ACK_OK : ACK_RETRY;

            case (state_q)
                ST_IDLE: begin
                    if (in_new) begin
                        flit_q  <= rou_in;
                        off_q   <= in_off;
                        tmo_q   <= '0;
                        state_q <= ((in_kind == K_WR || in_kind == K_RD) && in_hit)
                                   ? ST_LOCAL : ST_FWD;
                    end
                end
                ST_LOCAL: begin
                    // The latched request is turned into its response in place.
                    if (loc_ack) begin
                        flit_q[KL +: 2]   <= K_RSP;
                        flit_q[DWID-1:0]  <= loc_we ? '0 : loc_rdata;
                        state_q           <= ST_RESP;
                    end else if (tmo_q == TW'(LOC_TMO - 1)) begin
                        flit_q[KL +: 2]   <= K_RSP;
                        flit_q[DWID-1:0]  <= '1;
                        err_q             <= err_inc;
                        state_q           <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_RESP, ST_FWD: begin
                    if (!out_vld) begin
                        rou_out_q <= flit_q;
                    end else if (ack_out == ACK_OK) begin
                        rou_out_q <= '0;
                        state_q   <= ST_IDLE;
                    end else if (ack_out == ACK_ERR) begin
                        rou_out_q <= '0;
                        err_q     <= err_inc;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_in    = ack_in_q;
    assign rou_out   = rou_out_q;
    assign err_cnt   = err_q;
    assign loc_req   = (state_q == ST_LOCAL);
    assign loc_we    = loc_req && (flit_q[KL +: 2] == K_WR);
    assign loc_addr  = off_q;
    assign loc_wdata = flit_q[DWID-1:0];

endmodule

// File: tb/tb_rou_target.sv
// Scoreboard bench for rou_target: directed flits upstream, a programmable
// local slave and a downstream acker that checks each presented response.
module tb_rou_target;
    import rou_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned W  = 2 + DW + AW + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  rou_in = '0;
    logic [2:0]    ack_in;
    logic [W-1:0]  rou_out;
    logic [2:0]    ack_out = 3'b000;
    logic          loc_req;
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [DW-1:0] loc_wdata;
    logic [DW-1:0] loc_rdata = '0;
    logic          loc_ack = 1'b0;
    logic [7:0]    err_cnt;

    rou_target #(
        .DWID (DW), .AWID (AW), .CWID (CW),
        .BASE (32'h1000_0000), .SIZE (32'h0000_1000), .LOC_TMO (16)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .rou_in (rou_in), .ack_in (ack_in),
        .rou_out (rou_out), .ack_out (ack_out),
        .loc_req (loc_req), .loc_we (loc_we), .loc_addr (loc_addr),
        .loc_wdata (loc_wdata), .loc_rdata (loc_rdata), .loc_ack (loc_ack),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] flit;
        int           retries;
        logic [2:0]   fin;
        int           err;
        int           lat;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } loc_t;

    rsp_t sb[$];
    loc_t lq[$];

    int          slv_lat   = 0;
    bit          slv_never = 1'b0;
    logic [DW-1:0] slv_rdata = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [7:0] t,
                                        input logic [31:0] a, input logic [127:0] d);
        flit_t f;
        f.kind = k;
        f.cmd  = t;
        f.addr = a;
        f.data = d;
        return f;
    endfunction

    task automatic exp_rsp(input logic [W-1:0] f, input int retries, input logic [2:0] fin,
                           input int err, input int lat);
        rsp_t e;
        e.flit = f; e.retries = retries; e.fin = fin; e.err = err; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic exp_loc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        loc_t e;
        e.we = we; e.addr = a; e.wdata = d;
        lq.push_back(e);
    endtask

    // Upstream sender: hold the flit until ACK_OK is sampled, then remove it.
    task automatic send(input logic [W-1:0] f, output int retries);
        int n;
        retries = 0;
        n = 0;
        @(posedge clk);
        #1 rou_in = f;
        do begin
            @(negedge clk);
            if (ack_in == ACK_RETRY) retries++;
            n++;
        end while (ack_in !== ACK_OK && n < 300);
        if (ack_in !== ACK_OK) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_accept: ack_in %b after %0d cycles, required 001", ack_in, n);
            rou_in = '0;
        end else begin
            last_acc = cyc;
            @(posedge clk);
            #1 rou_in = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || lq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (sb.size() != 0 || lq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses and %0d local accesses outstanding, required 0",
                     sb.size(), lq.size());
            sb.delete();
            lq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Local slave: checks each access on its first cycle, acks after slv_lat cycles.
    int wcnt = 0;
    always @(negedge clk) begin
        if (!loc_req) begin
            loc_ack = 1'b0;
            wcnt = 0;
        end else if (!loc_ack) begin
            if (wcnt == 0) begin
                if (lq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL loc_req: asserted with addr %h, required no access", loc_addr);
                end else begin
                    chk("loc_we", W'(loc_we), W'(lq[0].we));
                    chk("loc_addr", W'(loc_addr), W'(lq[0].addr));
                    chk("loc_wdata", W'(loc_wdata), W'(lq[0].wdata));
                    void'(lq.pop_front());
                end
            end
            if (!slv_never && wcnt == slv_lat) begin
                loc_ack = 1'b1;
                loc_rdata = slv_rdata;
            end else begin
                wcnt++;
            end
        end
    end

    // Downstream monitor: compares every presented response against the scoreboard.
    int hold = 0;
    bit first = 1'b1;
    bit chk_clr = 1'b0;
    int clr_err = 0;
    always @(negedge clk) begin
        if (chk_clr) begin
            chk_clr = 1'b0;
            chk("rou_out_clear", rou_out, '0);
            chk("err_after", W'(err_cnt), W'(clr_err));
        end
        if (rou_out[W-1 -: 2] != K_IDLE) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rou_out: unexpected %h, required idle", rou_out);
                ack_out = ACK_OK;
            end else begin
                if (first && sb[0].lat != 0)
                    chk("latency", W'(cyc - last_acc), W'(sb[0].lat));
                first = 1'b0;
                chk("rou_out", rou_out, sb[0].flit);
                if (hold < sb[0].retries) begin
                    ack_out = ACK_RETRY;
                    hold++;
                end else begin
                    ack_out = sb[0].fin;
                    chk("err_cnt", W'(err_cnt), W'(sb[0].err));
                    clr_err = (sb[0].fin == ACK_ERR) ? sb[0].err + 1 : sb[0].err;
                    chk_clr = 1'b1;
                    void'(sb.pop_front());
                    hold = 0;
                    first = 1'b1;
                end
            end
        end else begin
            ack_out = ACK_NONE;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] miss_v [4];
    int r;

    initial begin
        miss_v[0] = mk(K_RD,  8'd7, 32'h2000_0000, 128'h55);
        miss_v[1] = mk(K_WR,  8'd1, 32'h1000_1000, 128'h11);
        miss_v[2] = mk(K_RD,  8'd2, 32'h0FFF_FFFF, 128'h0);
        miss_v[3] = mk(K_RSP, 8'd3, 32'h1000_0000, 128'h99);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rou_out", rou_out, '0);
        chk("rst_ack_in", W'(ack_in), W'(0));
        chk("rst_loc_req", W'(loc_req), W'(0));
        chk("rst_err_cnt", W'(err_cnt), W'(0));
        rst_n = 1'b1;

        // Zero-wait write hit.
        slv_lat = 0;
        exp_loc(1'b1, 32'h10, 128'hAB);
        exp_rsp(mk(K_RSP, 8'd5, 32'h1000_0010, 128'h0), 0, ACK_OK, 0, 2);
        send(mk(K_WR, 8'd5, 32'h1000_0010, 128'hAB), r);
        drain();

        // Read hit, slow slave, downstream holds off for four cycles.
        slv_lat = 3;
        slv_rdata = 128'hDEAD;
        exp_loc(1'b0, 32'h100, 128'h0);
        exp_rsp(mk(K_RSP, 8'd6, 32'h1000_0100, 128'hDEAD), 4, ACK_OK, 0, 0);
        send(mk(K_RD, 8'd6, 32'h1000_0100, 128'h0), r);
        drain();

        // Misses, window edges and responses pass through unchanged.
        for (int i = 0; i < 4; i++) begin
            exp_rsp(miss_v[i], 0, ACK_OK, 0, 1);
            send(miss_v[i], r);
            drain();
        end

        // Hits at the first and last byte of the window.
        slv_lat = 0;
        slv_rdata = 128'hBEEF;
        exp_loc(1'b0, 32'h0, 128'h0);
        exp_rsp(mk(K_RSP, 8'd4, 32'h1000_0000, 128'hBEEF), 0, ACK_OK, 0, 2);
        send(mk(K_RD, 8'd4, 32'h1000_0000, 128'h0), r);
        drain();
        slv_lat = 1;
        exp_loc(1'b1, 32'hFFF, 128'h1234);
        exp_rsp(mk(K_RSP, 8'd8, 32'h1000_0FFF, 128'h0), 0, ACK_OK, 0, 3);
        send(mk(K_WR, 8'd8, 32'h1000_0FFF, 128'h1234), r);
        drain();

        // Second flit arrives while the first is being served.
        slv_lat = 5;
        slv_rdata = 128'hCAFE;
        exp_loc(1'b0, 32'h200, 128'h0);
        exp_loc(1'b1, 32'h204, 128'h77);
        exp_rsp(mk(K_RSP, 8'h0A, 32'h1000_0200, 128'hCAFE), 0, ACK_OK, 0, 0);
        exp_rsp(mk(K_RSP, 8'h0B, 32'h1000_0204, 128'h0), 0, ACK_OK, 0, 0);
        send(mk(K_RD, 8'h0A, 32'h1000_0200, 128'h0), r);
        send(mk(K_WR, 8'h0B, 32'h1000_0204, 128'h77), r);
        chk("busy_retries", W'(r), W'(6));
        drain();

        // Local timeout, then the response is dropped downstream.
        slv_never = 1'b1;
        exp_loc(1'b0, 32'h40, 128'h0);
        exp_rsp(mk(K_RSP, 8'd3, 32'h1000_0040, {128{1'b1}}), 0, ACK_ERR, 1, 17);
        send(mk(K_RD, 8'd3, 32'h1000_0040, 128'h0), r);
        drain();

        // Reset during a local access; the waiting flit is then taken.
        exp_loc(1'b0, 32'h20, 128'h0);
        send(mk(K_RD, 8'h0C, 32'h1000_0020, 128'h0), r);
        exp_loc(1'b1, 32'h30, 128'h77);
        exp_rsp(mk(K_RSP, 8'd9, 32'h1000_0030, 128'h0), 0, ACK_OK, 0, 2);
        fork
            send(mk(K_WR, 8'd9, 32'h1000_0030, 128'h77), r);
            begin
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("mid_rst_rou_out", rou_out, '0);
                chk("mid_rst_ack_in", W'(ack_in), W'(0));
                chk("mid_rst_loc_req", W'(loc_req), W'(0));
                chk("mid_rst_err_cnt", W'(err_cnt), W'(0));
                slv_never = 1'b0;
                slv_lat = 0;
                rst_n = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
